// File: rtl/seg7_scan_if.sv
// Image load bus for seg7_scan_ctrl: parallel hex image, masks, brightness,
// load strobe, and the pending-commit flag returned by the scanner.
interface seg7_scan_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] i_digits;
    logic [NUM_DIGITS-1:0]   i_dp;
    logic [NUM_DIGITS-1:0]   i_blank;
    logic [3:0]              i_bright;
    logic                    i_load;
    logic                    o_pending;

    modport master (
        output i_digits, i_dp, i_blank, i_bright, i_load,
        input  o_pending
    );

    modport slave (
        input  i_digits, i_dp, i_blank, i_bright, i_load,
        output o_pending
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode seven-segment scanner with a double-buffered image
// committed at frame wraps. Define SEG7_SCAN_DIM_EN to enable PWM dimming.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS    = 8,
    parameter int PRESCALE_LOG2 = 14,
    parameter int BLANK_CYCLES  = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    seg7_scan_if.slave            bus,
    output logic                  o_frame,
    output logic [NUM_DIGITS-1:0] AN,
    output logic [6:0]            seg_n,
    output logic                  dp_n
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]         LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRESCALE_LOG2-1:0] BLANK_CNT = PRESCALE_LOG2'(BLANK_CYCLES);

    logic [PRESCALE_LOG2-1:0] slot_cnt_reg;
    logic [IDX_W-1:0]         idx_reg;
    logic                     terminal;
    logic                     wrap;

    logic [4*NUM_DIGITS-1:0]  stg_digits_reg, act_digits_reg;
    logic [NUM_DIGITS-1:0]    stg_dp_reg, act_dp_reg;
    logic [NUM_DIGITS-1:0]    stg_blank_reg, act_blank_reg;
    logic                     pending_reg;
`ifdef SEG7_SCAN_DIM_EN
    logic [3:0]               stg_bright_reg, act_bright_reg;
`endif

    logic [NUM_DIGITS-1:0]    an_sel;
    logic [3:0]               cur_digit;
    logic                     gate;
    logic                     lit;
    logic [NUM_DIGITS-1:0]    an_next, an_reg;
    logic [6:0]               seg_next, seg_reg;
    logic                     dp_next, dp_reg;
    logic                     frame_reg;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_to_seg = 7'b0000001;
            4'h1: hex_to_seg = 7'b1001111;
            4'h2: hex_to_seg = 7'b0010010;
            4'h3: hex_to_seg = 7'b0000110;
            4'h4: hex_to_seg = 7'b1001100;
            4'h5: hex_to_seg = 7'b0100100;
            4'h6: hex_to_seg = 7'b0100000;
            4'h7: hex_to_seg = 7'b0001111;
            4'h8: hex_to_seg = 7'b0000000;
            4'h9: hex_to_seg = 7'b0000100;
            4'hA: hex_to_seg = 7'b0001000;
            4'hB: hex_to_seg = 7'b1100000;
            4'hC: hex_to_seg = 7'b0110001;
            4'hD: hex_to_seg = 7'b1000010;
            4'hE: hex_to_seg = 7'b0110000;
            default: hex_to_seg = 7'b0111000;
        endcase
    endfunction

    assign terminal = &slot_cnt_reg;
    assign wrap     = terminal && (idx_reg == LAST_IDX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            slot_cnt_reg <= '0;
            idx_reg      <= '0;
        end else begin
            slot_cnt_reg <= slot_cnt_reg + 1'b1;
            if (terminal) begin
                idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
            end
        end
    end

    // A load coinciding with the wrap bypasses staging so it is not lost for a frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stg_digits_reg <= '0;
            stg_dp_reg     <= '0;
            stg_blank_reg  <= '1;
            act_digits_reg <= '0;
            act_dp_reg     <= '0;
            act_blank_reg  <= '1;
            pending_reg    <= 1'b0;
`ifdef SEG7_SCAN_DIM_EN
            stg_bright_reg <= 4'hF;
            act_bright_reg <= 4'hF;
`endif
        end else begin
            if (bus.i_load) begin
                stg_digits_reg <= bus.i_digits;
                stg_dp_reg     <= bus.i_dp;
                stg_blank_reg  <= bus.i_blank;
`ifdef SEG7_SCAN_DIM_EN
                stg_bright_reg <= bus.i_bright;
`endif
            end
            if (wrap) begin
                if (bus.i_load) begin
                    act_digits_reg <= bus.i_digits;
                    act_dp_reg     <= bus.i_dp;
                    act_blank_reg  <= bus.i_blank;
`ifdef SEG7_SCAN_DIM_EN
                    act_bright_reg <= bus.i_bright;
`endif
                end else if (pending_reg) begin
                    act_digits_reg <= stg_digits_reg;
                    act_dp_reg     <= stg_dp_reg;
                    act_blank_reg  <= stg_blank_reg;
`ifdef SEG7_SCAN_DIM_EN
                    act_bright_reg <= stg_bright_reg;
`endif
                end
                pending_reg <= 1'b0;
            end else if (bus.i_load) begin
                pending_reg <= 1'b1;
            end
        end
    end

    assign bus.o_pending = pending_reg;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an_sel
            assign an_sel[gi] = (idx_reg == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        cur_digit = act_digits_reg[{idx_reg, 2'b00} +: 4];
        gate      = 1'b1;
`ifdef SEG7_SCAN_DIM_EN
        // Top four slot bits form a 16-step PWM ramp within each slot.
        gate      = (slot_cnt_reg[PRESCALE_LOG2-1 -: 4] <= act_bright_reg);
`endif
        lit       = (slot_cnt_reg >= BLANK_CNT) && !act_blank_reg[idx_reg] && gate;
        an_next   = '1;
        seg_next  = 7'h7F;
        dp_next   = 1'b1;
        if (lit) begin
            an_next  = ~an_sel;
            seg_next = hex_to_seg(cur_digit);
            dp_next  = ~act_dp_reg[idx_reg];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            an_reg    <= '1;
            seg_reg   <= 7'h7F;
            dp_reg    <= 1'b1;
            frame_reg <= 1'b0;
        end else begin
            an_reg    <= an_next;
            seg_reg   <= seg_next;
            dp_reg    <= dp_next;
            frame_reg <= wrap;
        end
    end

    assign AN      = an_reg;
    assign seg_n   = seg_reg;
    assign dp_n    = dp_reg;
    assign o_frame = frame_reg;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed frame-by-frame bench for seg7_scan_ctrl with 4 digits, 32-cycle slots
// and 2 blank cycles; expectations follow SEG7_SCAN_DIM_EN when it is defined.
module tb_seg7_scan_ctrl;
    localparam int ND    = 4;
    localparam int PL2   = 5;
    localparam int BLK   = 2;
    localparam int SLOT  = 1 << PL2;
    localparam int FRAME = ND * SLOT;

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic [3:0]  bright;
    } img_t;

    typedef struct {
        int   load_t;
        img_t ld;
        int   load2_t;
        img_t ld2;
        img_t exp;
        string name;
    } vec_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          frame;
    logic [ND-1:0] an;
    logic [6:0]    seg_n;
    logic          dp_n;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic exp_pend = 1'b0;

    seg7_scan_if #(.NUM_DIGITS(ND)) bus ();

    seg7_scan_ctrl #(
        .NUM_DIGITS(ND), .PRESCALE_LOG2(PL2), .BLANK_CYCLES(BLK)
    ) dut (
        .clk(clk), .rstn(rstn), .bus(bus),
        .o_frame(frame), .AN(an), .seg_n(seg_n), .dp_n(dp_n)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] tbl [16];
        tbl = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
        return tbl[h];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input img_t im);
        bus.i_digits = im.digits;
        bus.i_dp     = im.dp;
        bus.i_blank  = im.blank;
        bus.i_bright = im.bright;
        bus.i_load   = 1'b1;
    endtask

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Runs one full frame starting at slot_cnt=0/idx=0, applying up to two loads.
    task automatic run_frame(input string name, input img_t exp, input int lt, input img_t ld,
                             input int lt2, input img_t ld2);
        int         s, d, slot_err, first_t, fbad;
        logic       lit, gate;
        logic [3:0] e_an, a_an;
        logic [6:0] e_seg, a_seg;
        logic       e_dp, a_dp;
        slot_err = 0; fbad = 0; first_t = 0;
        e_an = '1; a_an = '1; e_seg = '1; a_seg = '1; e_dp = 1'b1; a_dp = 1'b1;
        for (int t = 0; t < FRAME; t++) begin
            if (t == lt) drive(ld);
            else if (t == lt2) drive(ld2);
            tick();
            bus.i_load = 1'b0;
            if (t == lt || t == lt2) exp_pend = 1'b1;
            if (t == FRAME - 1) exp_pend = 1'b0;
            s = t % SLOT;
            d = t / SLOT;
`ifdef SEG7_SCAN_DIM_EN
            gate = ((s >> (PL2 - 4)) <= int'(exp.bright));
`else
            gate = 1'b1;
`endif
            lit = (s >= BLK) && !exp.blank[d] && gate;
            if (lit) begin
                if (an !== ~(4'b0001 << d) || seg_n !== hex7(exp.digits[4*d +: 4]) || dp_n !== ~exp.dp[d]) begin
                    if (slot_err == 0) begin
                        first_t = t; a_an = an; a_seg = seg_n; a_dp = dp_n;
                        e_an = ~(4'b0001 << d); e_seg = hex7(exp.digits[4*d +: 4]); e_dp = ~exp.dp[d];
                    end
                    slot_err++;
                end
            end else if (an !== 4'hF || seg_n !== 7'h7F || dp_n !== 1'b1) begin
                if (slot_err == 0) begin
                    first_t = t; a_an = an; a_seg = seg_n; a_dp = dp_n;
                    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
                end
                slot_err++;
            end
            if (frame !== (t == FRAME - 1)) fbad++;
            if (s == SLOT - 1) begin
                n_tests++;
                if (slot_err != 0) begin
                    n_fail++;
                    $display("FAIL %s digit%0d t=%0d: got AN=%h seg=%b dp=%b, expected AN=%h seg=%b dp=%b (%0d bad cycles)",
                             name, d, first_t, a_an, a_seg, a_dp, e_an, e_seg, e_dp, slot_err);
                end
                slot_err = 0;
                check1($sformatf("%s pending@digit%0d", name, d), {31'b0, bus.o_pending}, {31'b0, exp_pend});
            end
        end
        n_tests++;
        if (fbad != 0) begin
            n_fail++;
            $display("FAIL %s o_frame: got %0d wrong cycles, expected one pulse at t=%0d", name, fbad, FRAME - 1);
        end
        $display("[TB] frame %s done", name);
    endtask

    localparam img_t DARK = '{16'h0000, 4'b0000, 4'b1111, 4'hF};
    localparam img_t IA   = '{16'h8A10, 4'b0001, 4'b0000, 4'hF};
    localparam img_t IB   = '{16'h1111, 4'b0000, 4'b0000, 4'hF};
    localparam img_t IC   = '{16'hFFFF, 4'b1010, 4'b0000, 4'hF};
    localparam img_t ID   = '{16'h0123, 4'b0000, 4'b0100, 4'hF};
    localparam img_t IE   = '{16'h4567, 4'b0110, 4'b0001, 4'h3};
    localparam img_t IF_  = '{16'h89AB, 4'b1111, 4'b0000, 4'h0};
    localparam img_t IG   = '{16'hCDEF, 4'b0000, 4'b0000, 4'hF};
    localparam img_t IH   = '{16'h2345, 4'b1111, 4'b0000, 4'hF};

    vec_t vecs[10];

    initial begin
        vecs[0] = '{-1,  DARK, -1, DARK, DARK, "reset_dark"};
        vecs[1] = '{10,  IA,   -1, DARK, DARK, "load_a_hidden"};
        vecs[2] = '{-1,  DARK, -1, DARK, IA,   "show_a"};
        vecs[3] = '{50,  IB,   -1, DARK, IA,   "midframe_b_old_persists"};
        vecs[4] = '{-1,  DARK, -1, DARK, IB,   "show_b"};
        vecs[5] = '{127, IC,   -1, DARK, IB,   "bypass_c"};
        vecs[6] = '{20,  ID,   40, IE,   IC,   "show_c_two_loads"};
        vecs[7] = '{100, IF_,  -1, DARK, IE,   "show_e_bright3"};
        vecs[8] = '{60,  IG,   -1, DARK, IF_,  "show_f_bright0"};
        vecs[9] = '{-1,  DARK, -1, DARK, IG,   "show_g"};

        bus.i_digits = '0; bus.i_dp = '0; bus.i_blank = '0; bus.i_bright = '0; bus.i_load = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check1("reset AN",      {28'b0, an},     32'hF);
        check1("reset seg_n",   {25'b0, seg_n},  32'h7F);
        check1("reset dp_n",    {31'b0, dp_n},   32'h1);
        check1("reset o_frame", {31'b0, frame},  32'h0);
        check1("reset pending", {31'b0, bus.o_pending}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        for (int v = 0; v < 10; v++) begin
            run_frame(vecs[v].name, vecs[v].exp, vecs[v].load_t, vecs[v].ld, vecs[v].load2_t, vecs[v].ld2);
        end

        // Asynchronous reset while digit 1 is lit, with a load still pending.
        for (int t = 0; t <= 40; t++) begin
            if (t == 5) drive(IH);
            tick();
            bus.i_load = 1'b0;
        end
        check1("pre_reset AN",      {28'b0, an}, 32'hD);
        check1("pre_reset pending", {31'b0, bus.o_pending}, 32'h1);
        #2;
        rstn = 1'b0;
        #1;
        check1("async_reset AN",      {28'b0, an},     32'hF);
        check1("async_reset seg_n",   {25'b0, seg_n},  32'h7F);
        check1("async_reset dp_n",    {31'b0, dp_n},   32'h1);
        check1("async_reset pending", {31'b0, bus.o_pending}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        exp_pend = 1'b0;
        run_frame("post_reset_dark1", DARK, -1, DARK, -1, DARK);
        run_frame("post_reset_load",  DARK, 30, IA,   -1, DARK);
        run_frame("post_reset_show",  IA,   -1, DARK, -1, DARK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
